// File: rtl/div_unit_if.sv
// div_unit_if: execute-stage <-> divider handshake and operand/result bundle
// master (execute stage): drives div_en, div_signed, div_src1, div_src2, div_cancel
// slave  (div_unit):      drives div_busy (stall), div_done (1-cycle pulse), div_result {rem, quo}
interface div_unit_if;
   logic        div_en;
   logic        div_signed;
   logic        div_cancel;
   logic        div_busy;
   logic        div_done;
   logic [31:0] div_src1;
   logic [31:0] div_src2;
   logic [63:0] div_result;
   modport master (
      output div_en, div_signed, div_src1, div_src2, div_cancel,
      input  div_busy, div_done, div_result
   );
   modport slave (
      input  div_en, div_signed, div_src1, div_src2, div_cancel,
      output div_busy, div_done, div_result
   );
endinterface

// File: rtl/div_unit.sv
// div_unit: 32-bit radix-2 restoring divider, signed/unsigned, 33-cycle latency
// Ports: clk (rising edge), resetn (synchronous, active-low), bus (div_unit_if.slave):
//    div_en/div_signed/div_src1/div_src2 start an operation, div_cancel flushes it,
//    div_busy stalls the pipeline, div_done pulses when div_result {remainder, quotient} is new.
// Option: DIV_ZERO_FAST_EN -- a zero divisor finishes in one cycle with {src1, 32'hFFFFFFFF}.
module div_unit (
   input  logic      clk,
   input  logic      resetn,
   div_unit_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   logic [1:0]  state;
   logic [4:0]  cnt;
   logic [31:0] rem, quo, dvs;
   logic        neg_q, neg_r;
   logic [63:0] result;
   logic        start, fast_zero;
   logic [31:0] a_mag, b_mag;
   logic [32:0] diff;
   logic [31:0] rem_nx, quo_nx;
`ifdef DIV_ZERO_FAST_EN
   assign fast_zero = bus.div_src2 == 32'd0;
`else
   assign fast_zero = 1'b0;
`endif
   assign start        = (state == IDLE || state == DONE) && bus.div_en && !bus.div_cancel;
   assign bus.div_busy = (state == RUN) || start;
   assign bus.div_done = state == DONE;
   assign bus.div_result = result;
   assign a_mag = (bus.div_signed && bus.div_src1[31]) ? -bus.div_src1 : bus.div_src1;
   assign b_mag = (bus.div_signed && bus.div_src2[31]) ? -bus.div_src2 : bus.div_src2;
   // quo doubles as the dividend shift register: its MSB feeds the partial remainder
   always_comb begin
      diff   = {rem, quo[31]} - {1'b0, dvs};
      rem_nx = diff[32] ? {rem[30:0], quo[31]} : diff[31:0];
      quo_nx = {quo[30:0], ~diff[32]};
   end
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state  <= IDLE;
         cnt    <= '0;
         result <= '0;
      end else if (bus.div_cancel) begin
         state <= IDLE;
      end else if (start) begin
         state <= fast_zero ? DONE : RUN;
         cnt   <= '0;
         rem   <= '0;
         quo   <= a_mag;
         dvs   <= b_mag;
         neg_q <= bus.div_signed & (bus.div_src1[31] ^ bus.div_src2[31]);
         neg_r <= bus.div_signed & bus.div_src1[31];
         if (fast_zero) result <= {bus.div_src1, 32'hFFFF_FFFF};
      end else if (state == RUN) begin
         rem <= rem_nx;
         quo <= quo_nx;
         cnt <= cnt + 5'd1;
         if (cnt == 5'd31) begin
            state  <= DONE;
            result <= {neg_r ? -rem_nx : rem_nx, neg_q ? -quo_nx : quo_nx};
         end
      end else begin
         state <= IDLE;
      end
   end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard-based self-checking bench for div_unit
module tb_div_unit;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;
   div_unit_if bus ();
   div_unit dut (.clk(clk), .resetn(resetn), .bus(bus));
   logic [63:0] exp_q[$];
   logic [63:0] last_res;
   int n_cmp = 0;
   int n_err = 0;
   function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (s) begin
         sa = $signed(a);
         sb = $signed(b);
      end else begin
         sa = {32'd0, a};
         sb = {32'd0, b};
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction
   task automatic drive_start(input bit s, input logic [31:0] a, input logic [31:0] b);
      bus.div_en = 1'b1;
      bus.div_signed = s;
      bus.div_src1 = a;
      bus.div_src2 = b;
   endtask
   // called inside the start cycle; returns the cycle offset of div_done, or -1
   task automatic wait_done(output int cyc, output logic [63:0] res);
      cyc = -1;
      res = 'x;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk); #1;
         bus.div_en = 1'b0;
         @(negedge clk);
         if (bus.div_done === 1'b1) begin
            cyc = c;
            res = bus.div_result;
            break;
         end
      end
   endtask
   task automatic test_reset();
      bus.div_en = 1'b0;
      bus.div_cancel = 1'b0;
      bus.div_signed = 1'b0;
      bus.div_src1 = '0;
      bus.div_src2 = '0;
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (bus.div_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus.div_busy); end
      n_cmp++; if (bus.div_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", bus.div_done); end
      n_cmp++; if (bus.div_result !== 64'd0) begin n_err++; $display("FAIL reset_result: got %h expected 0", bus.div_result); end
      @(posedge clk); #1;
      resetn = 1'b1;
      last_res = 64'd0;
   endtask
   task automatic test_unsigned_timing();
      logic [63:0] e;
      drive_start(1'b0, 32'd100, 32'd7);
      exp_q.push_back(64'h00000002_0000000E);
      for (int c = 0; c <= 35; c++) begin
         @(negedge clk);
         n_cmp++; if (bus.div_busy !== (c <= 32)) begin n_err++; $display("FAIL u_busy c%0d: got %b expected %b", c, bus.div_busy, c <= 32); end
         n_cmp++; if (bus.div_done !== (c == 33)) begin n_err++; $display("FAIL u_done c%0d: got %b expected %b", c, bus.div_done, c == 33); end
         if (bus.div_done === 1'b1) begin
            e = exp_q.size() > 0 ? exp_q.pop_front() : 64'hx;
            n_cmp++; if (bus.div_result !== e) begin n_err++; $display("FAIL u_result: got %h expected %h", bus.div_result, e); end
            last_res = e;
         end
         @(posedge clk); #1;
         bus.div_en = 1'b0;
      end
   endtask
   task automatic test_signed();
      logic [31:0] a[4] = '{32'hFFFFFFF9, 32'h80000000, 32'h00000007, 32'hFFFFFF9C};
      logic [31:0] b[4] = '{32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFF9};
      logic [63:0] x[4] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000000_80000000, 64'h00000001_FFFFFFFD, 64'hFFFFFFFE_0000000E};
      logic [63:0] res, e;
      int cyc;
      for (int i = 0; i < 4; i++) begin
         drive_start(1'b1, a[i], b[i]);
         exp_q.push_back(x[i]);
         wait_done(cyc, res);
         e = exp_q.pop_front();
         n_cmp++; if (cyc !== 33) begin n_err++; $display("FAIL s_latency %0d: got %0d expected 33", i, cyc); end
         n_cmp++; if (res !== e) begin n_err++; $display("FAIL s_result %0d: got %h expected %h", i, res, e); end
         last_res = e;
         @(posedge clk); #1;
      end
   endtask
   task automatic test_back_to_back();
      logic [63:0] res, e;
      int cyc;
      drive_start(1'b0, 32'd6, 32'd4);
      exp_q.push_back(64'h00000002_00000001);
      wait_done(cyc, res);
      e = exp_q.pop_front();
      n_cmp++; if (cyc !== 33) begin n_err++; $display("FAIL b2b_lat1: got %0d expected 33", cyc); end
      n_cmp++; if (res !== e) begin n_err++; $display("FAIL b2b_res1: got %h expected %h", res, e); end
      drive_start(1'b0, 32'd9, 32'd3);
      exp_q.push_back(64'h00000000_00000003);
      #1;
      n_cmp++; if (bus.div_busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b expected 1", bus.div_busy); end
      wait_done(cyc, res);
      e = exp_q.pop_front();
      n_cmp++; if (cyc !== 33) begin n_err++; $display("FAIL b2b_lat2: got %0d expected 33", cyc); end
      n_cmp++; if (res !== e) begin n_err++; $display("FAIL b2b_res2: got %h expected %h", res, e); end
      last_res = e;
      @(posedge clk); #1;
   endtask
   task automatic test_cancel();
      int seen = 0;
      drive_start(1'b0, 32'd1000, 32'd3);
      for (int c = 1; c <= 11; c++) begin
         @(posedge clk); #1;
         bus.div_en = 1'b0;
      end
      bus.div_cancel = 1'b1;
      drive_start(1'b0, 32'd5, 32'd5);
      @(negedge clk);
      n_cmp++; if (bus.div_busy !== 1'b1) begin n_err++; $display("FAIL cancel_busy_run: got %b expected 1", bus.div_busy); end
      @(posedge clk); #1;
      bus.div_cancel = 1'b0;
      bus.div_en = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.div_busy !== 1'b0) begin n_err++; $display("FAIL cancel_busy_after: got %b expected 0", bus.div_busy); end
      n_cmp++; if (bus.div_result !== last_res) begin n_err++; $display("FAIL cancel_hold: got %h expected %h", bus.div_result, last_res); end
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.div_done === 1'b1) seen++;
      end
      n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL cancel_no_done: got %0d pulses expected 0", seen); end
      @(posedge clk); #1;
      bus.div_cancel = 1'b1;
      drive_start(1'b0, 32'd8, 32'd2);
      @(negedge clk);
      n_cmp++; if (bus.div_busy !== 1'b0) begin n_err++; $display("FAIL cancel_override_busy: got %b expected 0", bus.div_busy); end
      @(posedge clk); #1;
      bus.div_cancel = 1'b0;
      bus.div_en = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.div_busy !== 1'b0) begin n_err++; $display("FAIL cancel_override_idle: got %b expected 0", bus.div_busy); end
      @(posedge clk); #1;
   endtask
   task automatic test_reset_mid_run();
      logic [63:0] res, e;
      int cyc;
      int seen = 0;
      drive_start(1'b0, 32'd50, 32'd6);
      for (int c = 1; c <= 21; c++) begin
         @(posedge clk); #1;
         bus.div_en = 1'b0;
      end
      resetn = 1'b0;
      bus.div_en = 1'b1;
      @(posedge clk); #1;
      resetn = 1'b1;
      bus.div_en = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.div_busy !== 1'b0) begin n_err++; $display("FAIL rst_run_busy: got %b expected 0", bus.div_busy); end
      n_cmp++; if (bus.div_done !== 1'b0) begin n_err++; $display("FAIL rst_run_done: got %b expected 0", bus.div_done); end
      n_cmp++; if (bus.div_result !== 64'd0) begin n_err++; $display("FAIL rst_run_result: got %h expected 0", bus.div_result); end
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.div_done === 1'b1) seen++;
      end
      n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL rst_run_no_done: got %0d pulses expected 0", seen); end
      @(posedge clk); #1;
      drive_start(1'b0, 32'd15, 32'd4);
      exp_q.push_back(64'h00000003_00000003);
      wait_done(cyc, res);
      e = exp_q.pop_front();
      n_cmp++; if (cyc !== 33) begin n_err++; $display("FAIL rst_new_lat: got %0d expected 33", cyc); end
      n_cmp++; if (res !== e) begin n_err++; $display("FAIL rst_new_res: got %h expected %h", res, e); end
      @(posedge clk); #1;
   endtask
   task automatic test_div_zero();
      logic [63:0] res;
      int cyc;
      int lat;
`ifdef DIV_ZERO_FAST_EN
      logic [63:0] e;
      lat = 1;
      exp_q.push_back(64'h12345678_FFFFFFFF);
`else
      lat = 33;
`endif
      drive_start(1'b0, 32'h12345678, 32'd0);
      wait_done(cyc, res);
      n_cmp++; if (cyc !== lat) begin n_err++; $display("FAIL zero_latency: got %0d expected %0d", cyc, lat); end
      n_cmp++; if (bus.div_busy !== 1'b0) begin n_err++; $display("FAIL zero_busy_done: got %b expected 0", bus.div_busy); end
`ifdef DIV_ZERO_FAST_EN
      e = exp_q.pop_front();
      n_cmp++; if (res !== e) begin n_err++; $display("FAIL zero_result: got %h expected %h", res, e); end
`endif
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++; if (bus.div_busy !== 1'b0) begin n_err++; $display("FAIL zero_busy_after: got %b expected 0", bus.div_busy); end
      n_cmp++; if (bus.div_done !== 1'b0) begin n_err++; $display("FAIL zero_done_after: got %b expected 0", bus.div_done); end
      @(posedge clk); #1;
   endtask
   task automatic test_random();
      logic [63:0] res, e;
      logic [31:0] a, b;
      bit s;
      int cyc;
      for (int i = 0; i < 10; i++) begin
         a = $urandom;
         b = (i % 3 == 0) ? $urandom_range(1, 20) : $urandom;
         if (b == 32'd0) b = 32'd1;
         if (i % 4 == 1) b = -b;
         s = 1'($urandom_range(0, 1));
         drive_start(s, a, b);
         exp_q.push_back(model(s, a, b));
         wait_done(cyc, res);
         e = exp_q.pop_front();
         n_cmp++; if (cyc !== 33) begin n_err++; $display("FAIL rnd_latency %0d: got %0d expected 33", i, cyc); end
         n_cmp++; if (res !== e) begin n_err++; $display("FAIL rnd_result %0d (s=%0d %h/%h): got %h expected %h", i, s, a, b, res, e); end
         @(posedge clk); #1;
      end
   endtask
   initial begin
      test_reset();
      test_unsigned_timing();
      test_signed();
      test_back_to_back();
      test_cancel();
      test_reset_mid_run();
      test_div_zero();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
